// File: rtl/l2_cache_pkg.sv
// Shared encodings for the L2 tag/state cache model: command ops, bus ops,
// snoop results, MESI line states and FSM state constants.
package l2_cache_pkg;

    localparam int unsigned OP_RD    = 0;
    localparam int unsigned OP_WR    = 1;
    localparam int unsigned OP_IF    = 2;
    localparam int unsigned OP_SINV  = 3;
    localparam int unsigned OP_SRD   = 4;
    localparam int unsigned OP_SWR   = 5;
    localparam int unsigned OP_SRWIM = 6;
    localparam int unsigned OP_CLR   = 8;
    localparam int unsigned OP_PRN   = 9;

    // RWIM shares the 2-bit bus encoding slot 0
    localparam logic [1:0] BUS_RWIM  = 2'd0;
    localparam logic [1:0] BUS_READ  = 2'd1;
    localparam logic [1:0] BUS_WRITE = 2'd2;
    localparam logic [1:0] BUS_INV   = 2'd3;

    localparam logic [1:0] SNP_NOHIT = 2'd0;
    localparam logic [1:0] SNP_HIT   = 2'd1;
    localparam logic [1:0] SNP_HITM  = 2'd2;

    typedef enum logic [1:0] {ST_I = 2'd0, ST_S = 2'd1, ST_E = 2'd2, ST_M = 2'd3} mesi_e;

    localparam logic [2:0] S_CLEAR  = 3'd0;
    localparam logic [2:0] S_IDLE   = 3'd1;
    localparam logic [2:0] S_LOOKUP = 3'd2;
    localparam logic [2:0] S_BUSREQ = 3'd3;
    localparam logic [2:0] S_BUSRSP = 3'd4;
    localparam logic [2:0] S_DONE   = 3'd5;

endpackage

// File: rtl/l2_plru8.sv
// 8-way tree pseudo-LRU: bit 0 is the root, 1..2 the middle level, 3..6 the leaves.
// A bit of 0 points the victim search left (lower ways), 1 points right.
module l2_plru8 (
    input  logic [6:0] bits_i,
    input  logic [2:0] way_i,
    output logic [6:0] bits_o,
    output logic [2:0] victim_o
);

    logic v2, v1, v0;

    always_comb begin
        bits_o = bits_i;
        bits_o[0] = ~way_i[2];
        bits_o[way_i[2] ? 3'd2 : 3'd1] = ~way_i[1];
        bits_o[3'd3 + {1'b0, way_i[2:1]}] = ~way_i[0];
    end

    always_comb begin
        v2 = bits_i[0];
        v1 = bits_i[v2 ? 3'd2 : 3'd1];
        v0 = bits_i[3'd3 + {1'b0, v2, v1}];
        victim_o = {v2, v1, v0};
    end

endmodule

// File: rtl/l2_cache.sv
// 8-way MESI L2 tag/state model: L1 requests and snoops on one command port, serial own bus ops.
// Lookup result at accept+1, completion pulses at accept+2 when no bus op; cmd_ready only in IDLE.
module l2_cache
    import l2_cache_pkg::*;
#(
    parameter int WAYS      = 8,
    parameter int SETS      = 16384,
    parameter int LINE_BITS = 512,
    parameter int ADDR_W    = 32,
    parameter int CMD_W     = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [CMD_W-1:0]  cmd_op,
    input  logic [ADDR_W-1:0] cmd_addr,
    output logic              bus_valid,
    output logic [1:0]        bus_op,
    output logic [ADDR_W-1:0] bus_addr,
    input  logic [1:0]        snoop_in,
    output logic              snoop_out_vld,
    output logic [1:0]        snoop_out,
    output logic              hit,
    output logic              miss,
    output logic              read,
    output logic              write
);

    localparam int INDEX_W  = $clog2(SETS);
    localparam int OFFSET_W = $clog2(LINE_BITS / 8);
    localparam int TAG_W    = ADDR_W - INDEX_W - OFFSET_W;

    logic [TAG_W-1:0] tag_arr  [SETS][WAYS];
    mesi_e            st_arr   [SETS][WAYS];
    logic [6:0]       plru_arr [SETS];

    logic [2:0]         state_q, state_d;
    logic [INDEX_W-1:0] clr_idx_q, clr_idx_d;
    logic [CMD_W-1:0]   op_q, op_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [2:0]         way_q, way_d;
    logic               upd_q, upd_d, plru_q, plru_d, from_snp_q, from_snp_d, lhit_q, lhit_d;
    mesi_e              new_st_q, new_st_d;
    logic [1:0]         reply_q, reply_d, snp_res_q, snp_res_d;
    logic               pend_q, pend_d;
    logic [1:0]         pend_op_q, pend_op_d;
    logic [ADDR_W-1:0]  pend_addr_q, pend_addr_d;
    logic               bus_valid_q, bus_valid_d;
    logic [1:0]         bus_op_q, bus_op_d;
    logic [ADDR_W-1:0]  bus_addr_q, bus_addr_d;
    logic               hit_q, hit_d, miss_q, miss_d, read_q, read_d, write_q, write_d;
    logic               svld_q, svld_d;
    logic [1:0]         sout_q, sout_d;

    logic [INDEX_W-1:0] idx;
    logic [TAG_W-1:0]   tag;
    logic [ADDR_W-1:0]  line_addr, vic_addr, b_addr;
    logic               hit_any, inv_any, need_bus, go_done, is_l1, is_snp, cur_hit;
    logic [2:0]         hit_way, inv_way, vic_way;
    mesi_e              hit_st, vic_st, fin_st;
    logic [1:0]         b_op, cur_reply;
    logic [6:0]         plru_new;
    logic [2:0]         plru_vic;
    logic               unused_offset;

    assign idx           = addr_q[OFFSET_W +: INDEX_W];
    assign tag           = addr_q[ADDR_W-1 -: TAG_W];
    assign line_addr     = {addr_q[ADDR_W-1:OFFSET_W], {OFFSET_W{1'b0}}};
    assign unused_offset = ^addr_q[OFFSET_W-1:0];

    l2_plru8 u_plru (
        .bits_i   (plru_arr[idx]),
        .way_i    (way_q),
        .bits_o   (plru_new),
        .victim_o (plru_vic)
    );

    // Descending scan so the lowest-index invalid/matching way wins
    always_comb begin
        hit_any = 1'b0;
        hit_way = 3'd0;
        inv_any = 1'b0;
        inv_way = 3'd0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (st_arr[idx][w] == ST_I) begin
                inv_any = 1'b1;
                inv_way = 3'(w);
            end else if (tag_arr[idx][w] == tag) begin
                hit_any = 1'b1;
                hit_way = 3'(w);
            end
        end
        vic_way  = inv_any ? inv_way : plru_vic;
        hit_st   = st_arr[idx][hit_way];
        vic_st   = st_arr[idx][vic_way];
        vic_addr = {tag_arr[idx][vic_way], idx, {OFFSET_W{1'b0}}};
    end

    assign is_l1  = (op_q == CMD_W'(OP_RD)) || (op_q == CMD_W'(OP_WR)) || (op_q == CMD_W'(OP_IF));
    assign is_snp = (op_q == CMD_W'(OP_SINV)) || (op_q == CMD_W'(OP_SRD)) ||
                    (op_q == CMD_W'(OP_SWR)) || (op_q == CMD_W'(OP_SRWIM));
    assign cur_hit   = (state_q == S_LOOKUP) ? hit_any : lhit_q;
    assign cur_reply = (state_q == S_LOOKUP) ? reply_d : reply_q;

    always_comb begin
        state_d     = state_q;
        clr_idx_d   = clr_idx_q;
        op_d        = op_q;
        addr_d      = addr_q;
        way_d       = way_q;
        upd_d       = upd_q;
        plru_d      = plru_q;
        from_snp_d  = from_snp_q;
        lhit_d      = lhit_q;
        new_st_d    = new_st_q;
        reply_d     = reply_q;
        snp_res_d   = snp_res_q;
        pend_d      = pend_q;
        pend_op_d   = pend_op_q;
        pend_addr_d = pend_addr_q;
        bus_valid_d = 1'b0;
        bus_op_d    = bus_op_q;
        bus_addr_d  = bus_addr_q;
        need_bus    = 1'b0;
        go_done     = 1'b0;
        b_op        = BUS_READ;
        b_addr      = line_addr;
        case (state_q)
            S_CLEAR: begin
                clr_idx_d = clr_idx_q + 1'b1;
                if (clr_idx_q == INDEX_W'(SETS - 1)) state_d = S_IDLE;
            end
            S_IDLE: begin
                if (cmd_valid) begin
                    op_d      = cmd_op;
                    addr_d    = cmd_addr;
                    clr_idx_d = '0;
                    state_d   = (cmd_op == CMD_W'(OP_CLR)) ? S_CLEAR : S_LOOKUP;
                end
            end
            S_LOOKUP: begin
                upd_d      = 1'b0;
                plru_d     = 1'b0;
                from_snp_d = 1'b0;
                pend_d     = 1'b0;
                lhit_d     = hit_any;
                way_d      = hit_way;
                new_st_d   = hit_st;
                reply_d    = SNP_NOHIT;
                if (op_q == CMD_W'(OP_RD) || op_q == CMD_W'(OP_IF) || op_q == CMD_W'(OP_WR)) begin
                    plru_d = 1'b1;
                    upd_d  = 1'b1;
                    if (op_q == CMD_W'(OP_WR)) new_st_d = ST_M;
                    if (!hit_any) begin
                        way_d      = vic_way;
                        need_bus   = 1'b1;
                        from_snp_d = (op_q != CMD_W'(OP_WR));
                        pend_op_d  = (op_q == CMD_W'(OP_WR)) ? BUS_RWIM : BUS_READ;
                        if (vic_st == ST_M) begin
                            b_op        = BUS_WRITE;
                            b_addr      = vic_addr;
                            pend_d      = 1'b1;
                            pend_addr_d = line_addr;
                        end else begin
                            b_op = pend_op_d;
                        end
                    end else if (op_q == CMD_W'(OP_WR) && hit_st == ST_S) begin
                        need_bus = 1'b1;
                        b_op     = BUS_INV;
                    end
                end else if (op_q == CMD_W'(OP_SRD) || op_q == CMD_W'(OP_SRWIM)) begin
                    if (hit_any) begin
                        upd_d    = 1'b1;
                        new_st_d = (op_q == CMD_W'(OP_SRD)) ? ST_S : ST_I;
                        reply_d  = (hit_st == ST_M) ? SNP_HITM : SNP_HIT;
                        need_bus = (hit_st == ST_M);
                        b_op     = BUS_WRITE;
                    end
                end else if (op_q == CMD_W'(OP_SINV)) begin
                    if (hit_any && hit_st == ST_S) begin
                        upd_d    = 1'b1;
                        new_st_d = ST_I;
                        reply_d  = SNP_HIT;
                    end
                end
                if (need_bus) begin
                    state_d     = S_BUSREQ;
                    bus_valid_d = 1'b1;
                    bus_op_d    = b_op;
                    bus_addr_d  = b_addr;
                end else begin
                    go_done = 1'b1;
                end
            end
            S_BUSREQ: state_d = S_BUSRSP;
            S_BUSRSP: begin
                snp_res_d = snoop_in;
                if (pend_q) begin
                    pend_d      = 1'b0;
                    bus_valid_d = 1'b1;
                    bus_op_d    = pend_op_q;
                    bus_addr_d  = pend_addr_q;
                    state_d     = S_BUSREQ;
                end else begin
                    go_done = 1'b1;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_CLEAR;
        endcase
        if (go_done) state_d = S_DONE;
        hit_d   = go_done && is_l1 && cur_hit;
        miss_d  = go_done && is_l1 && !cur_hit;
        read_d  = go_done && (op_q == CMD_W'(OP_RD) || op_q == CMD_W'(OP_IF));
        write_d = go_done && (op_q == CMD_W'(OP_WR));
        svld_d  = go_done && is_snp;
        sout_d  = (go_done && is_snp) ? cur_reply : SNP_NOHIT;
    end

    // A read fill lands in S if another cache reported a copy, otherwise E
    assign fin_st = from_snp_q ? ((snp_res_q == SNP_NOHIT) ? ST_E : ST_S) : new_st_q;

    always_ff @(posedge clk) begin
        if (state_q == S_CLEAR) begin
            for (int w = 0; w < WAYS; w++) st_arr[clr_idx_q][w] <= ST_I;
            plru_arr[clr_idx_q] <= 7'd0;
        end else if (state_q == S_DONE) begin
            if (upd_q) begin
                st_arr[idx][way_q]  <= fin_st;
                tag_arr[idx][way_q] <= tag;
            end
            if (plru_q) plru_arr[idx] <= plru_new;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_CLEAR;
            clr_idx_q   <= '0;
            op_q        <= '0;
            addr_q      <= '0;
            way_q       <= 3'd0;
            upd_q       <= 1'b0;
            plru_q      <= 1'b0;
            from_snp_q  <= 1'b0;
            lhit_q      <= 1'b0;
            new_st_q    <= ST_I;
            reply_q     <= SNP_NOHIT;
            snp_res_q   <= SNP_NOHIT;
            pend_q      <= 1'b0;
            pend_op_q   <= 2'd0;
            pend_addr_q <= '0;
            bus_valid_q <= 1'b0;
            bus_op_q    <= 2'd0;
            bus_addr_q  <= '0;
            hit_q       <= 1'b0;
            miss_q      <= 1'b0;
            read_q      <= 1'b0;
            write_q     <= 1'b0;
            svld_q      <= 1'b0;
            sout_q      <= 2'd0;
        end else begin
            state_q     <= state_d;
            clr_idx_q   <= clr_idx_d;
            op_q        <= op_d;
            addr_q      <= addr_d;
            way_q       <= way_d;
            upd_q       <= upd_d;
            plru_q      <= plru_d;
            from_snp_q  <= from_snp_d;
            lhit_q      <= lhit_d;
            new_st_q    <= new_st_d;
            reply_q     <= reply_d;
            snp_res_q   <= snp_res_d;
            pend_q      <= pend_d;
            pend_op_q   <= pend_op_d;
            pend_addr_q <= pend_addr_d;
            bus_valid_q <= bus_valid_d;
            bus_op_q    <= bus_op_d;
            bus_addr_q  <= bus_addr_d;
            hit_q       <= hit_d;
            miss_q      <= miss_d;
            read_q      <= read_d;
            write_q     <= write_d;
            svld_q      <= svld_d;
            sout_q      <= sout_d;
        end
    end

    assign cmd_ready     = (state_q == S_IDLE);
    assign bus_valid     = bus_valid_q;
    assign bus_op        = bus_op_q;
    assign bus_addr      = bus_addr_q;
    assign snoop_out_vld = svld_q;
    assign snoop_out     = sout_q;
    assign hit           = hit_q;
    assign miss          = miss_q;
    assign read          = read_q;
    assign write         = write_q;

endmodule

// File: tb/tb_l2_cache.sv
// Scoreboard bench for l2_cache with SETS=16: directed ops push expected bus and
// completion events; a negedge monitor pops and compares whatever the DUT presents.
module tb_l2_cache;

    localparam logic [1:0] B_RWIM = 2'd0, B_READ = 2'd1, B_WRITE = 2'd2, B_INV = 2'd3;
    // completion flags: {hit, miss, read, write, snoop_out_vld, snoop_out[1:0]}
    localparam logic [6:0] MISS_RD = 7'b0110000;
    localparam logic [6:0] HIT_RD  = 7'b1010000;
    localparam logic [6:0] MISS_WR = 7'b0101000;
    localparam logic [6:0] HIT_WR  = 7'b1001000;
    localparam logic [6:0] SNP_NO  = 7'b0000100;
    localparam logic [6:0] SNP_HT  = 7'b0000101;
    localparam logic [6:0] SNP_HM  = 7'b0000110;

    logic        clk = 1'b0, rst_n = 1'b0;
    logic        cmd_valid = 1'b0, cmd_ready;
    logic [7:0]  cmd_op = 8'd0;
    logic [31:0] cmd_addr = 32'd0;
    logic        bus_valid;
    logic [1:0]  bus_op;
    logic [31:0] bus_addr;
    logic [1:0]  snoop_in = 2'd0;
    logic        snoop_out_vld;
    logic [1:0]  snoop_out;
    logic        hit, miss, read, write;

    l2_cache #(.SETS(16)) dut (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_addr(cmd_addr), .bus_valid(bus_valid), .bus_op(bus_op),
        .bus_addr(bus_addr), .snoop_in(snoop_in), .snoop_out_vld(snoop_out_vld),
        .snoop_out(snoop_out), .hit(hit), .miss(miss), .read(read), .write(write)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        kind;   // 0 bus op, 1 completion
        logic [1:0]  bop;
        logic [31:0] baddr;
        logic [6:0]  flags;
        logic [7:0]  lat;    // 0 = latency not checked
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0, errors = 0;
    int   cyc = 0, acc_cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void push_bus(input logic [1:0] op, input logic [31:0] a);
        exp_t e;
        e = '{kind: 1'b0, bop: op, baddr: a, flags: 7'd0, lat: 8'd0};
        exp_q.push_back(e);
    endfunction

    function automatic void push_done(input logic [6:0] f, input logic [7:0] lat);
        exp_t e;
        e = '{kind: 1'b1, bop: 2'd0, baddr: 32'd0, flags: f, lat: lat};
        exp_q.push_back(e);
    endfunction

    exp_t       me;
    logic [6:0] fl;
    always @(negedge clk) begin
        fl = {hit, miss, read, write, snoop_out_vld, snoop_out};
        if (bus_valid) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL bus_unexpected: got op=%0d addr=%h, expected nothing", bus_op, bus_addr);
            end else begin
                me = exp_q.pop_front();
                if (me.kind != 1'b0 || bus_op != me.bop || bus_addr != me.baddr) begin
                    errors++;
                    $display("FAIL bus_op: got op=%0d addr=%h, expected kind=%0d op=%0d addr=%h",
                             bus_op, bus_addr, me.kind, me.bop, me.baddr);
                end
            end
        end
        if (|fl[6:2]) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL done_unexpected: got flags=%b, expected nothing", fl);
            end else begin
                me = exp_q.pop_front();
                if (me.kind != 1'b1 || fl != me.flags ||
                    (me.lat != 8'd0 && (cyc - acc_cyc) != int'(me.lat))) begin
                    errors++;
                    $display("FAIL done: got flags=%b lat=%0d, expected kind=%0d flags=%b lat=%0d",
                             fl, cyc - acc_cyc, me.kind, me.flags, me.lat);
                end
            end
        end
    end

    // Called at a negedge; returns at the negedge where cmd_ready is back.
    task automatic issue(input logic [7:0] op, input logic [31:0] a, input logic [1:0] snp);
        int n;
        n = 0;
        while (!cmd_ready && n < 100) begin @(negedge clk); n++; end
        snoop_in  = snp;
        cmd_op    = op;
        cmd_addr  = a;
        cmd_valid = 1'b1;
        acc_cyc   = cyc;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        @(negedge clk);
        n = 0;
        while (!cmd_ready && n < 100) begin @(negedge clk); n++; end
        checks++;
        if (!cmd_ready || exp_q.size() != 0) begin
            errors++;
            $display("FAIL complete op=%0d addr=%h: ready=%b pending=%0d, expected ready=1 pending=0",
                     op, a, cmd_ready, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic check_idle_outputs(input string name);
        checks++;
        if ({cmd_ready, bus_valid, hit, miss, read, write, snoop_out_vld} != 7'd0 ||
            snoop_out != 2'd0 || bus_op != 2'd0 || bus_addr != 32'd0) begin
            errors++;
            $display("FAIL %s: got rdy=%b bv=%b op=%0d addr=%h flags=%b, expected all zero", name,
                     cmd_ready, bus_valid, bus_op, bus_addr,
                     {hit, miss, read, write, snoop_out_vld, snoop_out});
        end
    endtask

    task automatic wait_clear(input string name);
        int n;
        n = 0;
        while (!cmd_ready && n < 40) begin @(negedge clk); n++; end
        checks++;
        if (n != 16) begin
            errors++;
            $display("FAIL %s: got ready after %0d cycles, expected 16", name, n);
        end
    endtask

    initial begin
        int n;
        logic [31:0] a;
        repeat (3) @(negedge clk);
        check_idle_outputs("reset_state");
        rst_n = 1'b1;
        wait_clear("clear_after_reset");

        push_bus(B_READ, 32'h1000); push_done(MISS_RD, 8'd0); issue(8'd0, 32'h1000, 2'd0);
        push_done(HIT_RD, 8'd2);  issue(8'd0, 32'h1004, 2'd0);
        push_done(HIT_WR, 8'd2);  issue(8'd1, 32'h1000, 2'd0);
        push_bus(B_WRITE, 32'h1000); push_done(SNP_HM, 8'd0); issue(8'd4, 32'h1000, 2'd0);
        push_bus(B_INV, 32'h1000); push_done(HIT_WR, 8'd0); issue(8'd1, 32'h1000, 2'd0);
        push_done(SNP_NO, 8'd2);  issue(8'd3, 32'h1000, 2'd0);
        push_done(SNP_NO, 8'd2);  issue(8'd5, 32'h1000, 2'd0);
        issue(8'd9, 32'h1000, 2'd0);
        issue(8'd7, 32'h1000, 2'd0);

        push_bus(B_READ, 32'h2000); push_done(MISS_RD, 8'd0); issue(8'd0, 32'h2008, 2'd1);
        push_done(SNP_HT, 8'd2);  issue(8'd6, 32'h2000, 2'd0);
        push_bus(B_READ, 32'h2000); push_done(MISS_RD, 8'd0); issue(8'd0, 32'h2000, 2'd0);
        push_done(HIT_RD, 8'd2);  issue(8'd2, 32'h2000, 2'd0);
        push_done(SNP_HT, 8'd2);  issue(8'd4, 32'h2000, 2'd0);
        push_bus(B_INV, 32'h2000); push_done(HIT_WR, 8'd0); issue(8'd1, 32'h2000, 2'd0);

        // set 1 filled with tags 1..8, all M; ways touched in order leave way 0 as PLRU victim
        for (int t = 1; t <= 8; t++) begin
            a = (32'(t) << 10) | 32'h40;
            push_bus(B_RWIM, a); push_done(MISS_WR, 8'd0); issue(8'd1, a, 2'd0);
        end
        push_bus(B_WRITE, 32'h0440); push_bus(B_RWIM, 32'h2440); push_done(MISS_WR, 8'd0);
        issue(8'd1, 32'h2440, 2'd0);
        push_done(HIT_RD, 8'd2);  issue(8'd0, 32'h0840, 2'd0);

        issue(8'd8, 32'h0, 2'd0);
        push_bus(B_READ, 32'h1000); push_done(MISS_RD, 8'd0); issue(8'd0, 32'h1000, 2'd0);
        push_bus(B_RWIM, 32'h0840); push_done(MISS_WR, 8'd0); issue(8'd1, 32'h0840, 2'd0);

        // reset while waiting on the bus response aborts the fill
        push_bus(B_READ, 32'h3000);
        snoop_in = 2'd0; cmd_op = 8'd0; cmd_addr = 32'h3000; cmd_valid = 1'b1;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        @(negedge clk);
        n = 0;
        while (!bus_valid && n < 20) begin @(negedge clk); n++; end
        checks++;
        if (!bus_valid) begin
            errors++;
            $display("FAIL abort_busreq: got bus_valid=0, expected 1");
        end
        @(negedge clk);
        rst_n = 1'b0;
        #1 check_idle_outputs("abort_outputs");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        wait_clear("clear_after_abort");
        push_bus(B_READ, 32'h3000); push_done(MISS_RD, 8'd0); issue(8'd0, 32'h3000, 2'd0);
        push_done(HIT_RD, 8'd2);  issue(8'd0, 32'h3000, 2'd0);

        repeat (3) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL leftover: got %0d pending events, expected 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule
